// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control FSM.
// The S_HALT state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_PC_INC  = 4'd10,
    S_JAL     = 4'd11,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_JAL_WB  = 4'd12,
    S_HALT    = 4'd13
`else
    S_JAL_WB  = 4'd12
`endif
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // bit positions in the one-hot opcode class vector
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_W      = 6;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: one-hot class vector plus legal flag.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]       opcode,
  output logic [CLS_W-1:0] op_class,
  output logic             legal
);

  always_comb begin
    op_class = '0;
    unique case (opcode)
      OP_R:      op_class[CLS_R]      = 1'b1;
      OP_I:      op_class[CLS_I]      = 1'b1;
      OP_LOAD:   op_class[CLS_LOAD]   = 1'b1;
      OP_STORE:  op_class[CLS_STORE]  = 1'b1;
      OP_BRANCH: op_class[CLS_BRANCH] = 1'b1;
      OP_JAL:    op_class[CLS_JAL]    = 1'b1;
      default:   op_class = '0;
    endcase
  end

  assign legal = |op_class;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the RV32I multicycle core (Moore, except pc_en/ir_write).
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT instead of acting as NOP.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, load IR on mem_ready
// DECODE    | ALUOut <= PC + Imm, dispatch on opcode class
// MEM_ADR   | ALUOut <= A + Imm (effective address)
// MEM_RD    | load data read, waits for mem_ready
// MEM_WB    | rd <= MDR, PC += 4
// MEM_WR    | store data write, waits for mem_ready
// EXEC_R    | ALUOut <= A op B
// EXEC_I    | ALUOut <= A op Imm
// ALU_WB    | rd <= ALUOut, PC += 4
// BRANCH    | compare A-B, PC <= ALUOut when taken
// PC_INC    | PC += 4
// JAL       | PC <= ALUOut, ALUOut <= PC + 4
// JAL_WB    | rd <= ALUOut (link address)
// HALT      | illegal opcode trap, left only by reset
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               pc_source,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t           state;
  state_t           state_next;
  logic [CLS_W-1:0] op_class;
  logic             op_legal;
  logic             taken;
  logic             unused_funct3;

  opcode_class_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .legal    (op_legal)
  );

  // beq/bne differ only in funct3[0]
  assign taken         = alu_zero ^ funct3[0];
  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_source  = 1'b0;
    illegal    = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        if (!op_legal)
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          state_next = S_PC_INC;
`endif
        else if (op_class[CLS_R])                        state_next = S_EXEC_R;
        else if (op_class[CLS_I])                        state_next = S_EXEC_I;
        else if (op_class[CLS_LOAD] || op_class[CLS_STORE]) state_next = S_MEM_ADR;
        else if (op_class[CLS_BRANCH])                   state_next = S_BRANCH;
        else                                             state_next = S_JAL;
      end
      S_MEM_ADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = op_class[CLS_STORE] ? S_MEM_WR : S_MEM_RD;
      end
      // address ALU inputs stay put so ALUOut is stable across wait states
      S_MEM_RD: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (mem_ready) state_next = S_PC_INC;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_SUB;
        pc_source  = 1'b1;
        pc_en      = taken;
        state_next = taken ? S_FETCH : S_PC_INC;
      end
      S_PC_INC: begin
        alu_src_b  = SRCB_FOUR;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        pc_en      = 1'b1;
        pc_source  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        state_next = S_JAL_WB;
      end
      S_JAL_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal    = 1'b1;
        state_next = S_HALT;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // reset masks every control output, including the FETCH read request
    if (!rst_n) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state);

endmodule
